// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   - RESET_PC_DEFAULT : PC value loaded on reset
//   - state_t / ST_*   : sequencer state encodings
//   - pcsel_t / PCSEL_*: next-PC source selection from the controller
package fetch_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_EXEC  = 2'd2;
    localparam state_t ST_HALT  = 2'd3;

    typedef logic [1:0] pcsel_t;
    localparam pcsel_t PCSEL_SEQ = 2'b00;
    localparam pcsel_t PCSEL_BR  = 2'b01;
    localparam pcsel_t PCSEL_J   = 2'b10;
    localparam pcsel_t PCSEL_JR  = 2'b11;

endpackage

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Combinational next-PC selection.
// Ports:
//   pcsel         in  2      source select (seq / branch / jump / jump-register)
//   pc_plus4      in  NBITS  address of the sequential successor
//   signimm       in  NBITS  sign-extended branch immediate (word offset)
//   instr_idx     in  26     jump target index field of the instruction
//   jr_target     in  NBITS  register operand for JR
//   next_pc       out NBITS  selected next PC
//   jr_misaligned out 1      JR selected and the register target is not word aligned
module next_pc_mux
    import fetch_sequencer_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [1:0]       pcsel,
    input  logic [NBITS-1:0] pc_plus4,
    input  logic [NBITS-1:0] signimm,
    input  logic [25:0]      instr_idx,
    input  logic [NBITS-1:0] jr_target,
    output logic [NBITS-1:0] next_pc,
    output logic             jr_misaligned
);

    always_comb begin
        next_pc       = pc_plus4;
        jr_misaligned = 1'b0;
        case (pcsel)
            PCSEL_SEQ: next_pc = pc_plus4;
            PCSEL_BR:  next_pc = pc_plus4 + (signimm << 2);
            PCSEL_J:   next_pc = {pc_plus4[NBITS-1:NBITS-4], instr_idx, 2'b00};
            PCSEL_JR: begin
                // Low bits are dropped so fetch stays word aligned; the
                // offending target is flagged instead of trapping.
                next_pc       = {jr_target[NBITS-1:2], 2'b00};
                jr_misaligned = |jr_target[1:0];
            end
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the MIPS datapath. Owns the PC, fetches
// over a req/ack handshake with variable latency, holds the instruction for
// one execute cycle and emits a single-cycle execute strobe per instruction.
//
// state | meaning
// IDLE  | out of reset, waiting for run
// FETCH | imem_req high at pc, waiting for imem_ack
// EXEC  | enable high for one cycle, pc/retired update at the edge
// HALT  | stopped after retiring an instruction, pc held
//
// Ports:
//   clk        in  1   system clock
//   reset_n    in  1   asynchronous active-low reset
//   run        in  1   keep executing (0 = halt after current instruction)
//   imem_req   out 1   fetch request, high for the whole FETCH state
//   imem_addr  out 32  fetch address (= pc)
//   imem_ack   in  1   imem_rdata valid this cycle
//   imem_rdata in  32  instruction word
//   instr      out 32  latched instruction
//   pc         out 32  address of current instruction
//   pc_plus4   out 32  pc + 4
//   enable     out 1   execute strobe, one cycle per instruction
//   pcsel      in  2   next-PC source from the controller
//   signimm    in  32  sign-extended immediate
//   jr_target  in  32  JR register operand
//   misalign   out 1   sticky misaligned-JR flag
//   retired    out 32  executed instruction count
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              NBITS    = 32,
    parameter logic [NBITS-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    output logic             imem_req,
    output logic [NBITS-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [NBITS-1:0] imem_rdata,
    output logic [NBITS-1:0] instr,
    output logic [NBITS-1:0] pc,
    output logic [NBITS-1:0] pc_plus4,
    output logic             enable,
    input  logic [1:0]       pcsel,
    input  logic [NBITS-1:0] signimm,
    input  logic [NBITS-1:0] jr_target,
    output logic             misalign,
    output logic [31:0]      retired
);

    state_t           state_q, state_d;
    logic [NBITS-1:0] pc_q;
    logic [NBITS-1:0] instr_q;
    logic [31:0]      retired_q;
    logic             misalign_q;
    logic [NBITS-1:0] pc_plus4_w;
    logic [NBITS-1:0] next_pc_w;
    logic             jr_misaligned_w;

    assign pc_plus4_w = pc_q + NBITS'(4);

    next_pc_mux #(.NBITS(NBITS)) u_next_pc_mux (
        .pcsel         (pcsel),
        .pc_plus4      (pc_plus4_w),
        .signimm       (signimm),
        .instr_idx     (instr_q[25:0]),
        .jr_target     (jr_target),
        .next_pc       (next_pc_w),
        .jr_misaligned (jr_misaligned_w)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_EXEC;
            ST_EXEC:  state_d = run ? ST_FETCH : ST_HALT;
            ST_HALT:  if (run) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            retired_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && imem_ack) begin
                instr_q <= imem_rdata;
            end
            if (state_q == ST_EXEC) begin
                pc_q      <= next_pc_w;
                retired_q <= retired_q + 32'd1;
                if (jr_misaligned_w) begin
                    misalign_q <= 1'b1;
                end
            end
        end
    end

    // Request and strobe decode straight from the state register so that an
    // asynchronous reset drops them in the same cycle.
    assign imem_req  = (state_q == ST_FETCH);
    assign enable    = (state_q == ST_EXEC);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_w;
    assign misalign  = misalign_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        enable;
    logic [1:0]  pcsel;
    logic [31:0] signimm;
    logic [31:0] jr_target;
    logic        misalign;
    logic [31:0] retired;

    fetch_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .enable     (enable),
        .pcsel      (pcsel),
        .signimm    (signimm),
        .jr_target  (jr_target),
        .misalign   (misalign),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] ret;
        logic        mis;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [1:0]  sel;
        logic [31:0] imm;
        logic [31:0] jr;
    } dir_t;

    exp_t exp_q[$];
    dir_t dir_q[$];

    int errors = 0;
    int checks = 0;

    // reference architectural state
    logic [31:0] m_pc     = RST_PC;
    logic [31:0] m_ret    = 0;
    logic        m_mis    = 0;
    logic [31:0] m_instr  = 0;
    logic        mem_en   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] sel,
                                             input logic [31:0] imm, input logic [31:0] ins,
                                             input logic [31:0] jr);
        logic [31:0] seq;
        seq = cur + 32'd4;
        case (sel)
            2'd0:    return seq;
            2'd1:    return seq + imm * 32'd4;
            2'd2:    return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
            default: return jr & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Stimulus: memory responder, controller operands, and the reference model.
    initial begin : stim
        int          lat;
        logic        pending;
        logic        cur_valid;
        dir_t        cur;
        logic [31:0] rd;
        logic [1:0]  sel;
        logic [31:0] imm;
        logic [31:0] jr;
        logic [15:0] r16;
        pending   = 0;
        cur_valid = 0;
        lat       = 0;
        cur       = '{0, 32'h0, 2'd0, 32'h0, 32'h0};
        imem_ack  = 1'b0;
        imem_rdata = '0;
        pcsel     = 2'd0;
        signimm   = '0;
        jr_target = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_pc    = RST_PC;
                m_ret   = 0;
                m_mis   = 0;
                m_instr = 0;
                exp_q.delete();
                pending   = 0;
                cur_valid = 0;
                imem_ack  = 1'b1;          // ack while in reset must be ignored
                imem_rdata = 32'hDEAD_BEEF;
                continue;
            end
            if (!mem_en) begin
                pending  = 0;
                imem_ack = 1'b0;
            end else if (imem_req) begin
                chk("imem_addr", imem_addr, m_pc);
                chk("instr_hold", instr, m_instr);
                if (!pending) begin
                    pending = 1;
                    if (!cur_valid && dir_q.size() > 0) begin
                        cur       = dir_q.pop_front();
                        cur_valid = 1;
                        lat       = cur.lat;
                    end else begin
                        lat = $urandom_range(0, 3);
                    end
                end
                if (lat == 0) begin
                    rd         = cur_valid ? cur.rdata : $urandom;
                    imem_ack   = 1'b1;
                    imem_rdata = rd;
                    exp_q.push_back('{m_pc, rd, m_ret, m_mis});
                    m_instr = rd;
                    pending = 0;
                end else begin
                    lat--;
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end

            if (enable) begin
                if (cur_valid) begin
                    sel = cur.sel; imm = cur.imm; jr = cur.jr;
                    cur_valid = 0;
                end else begin
                    sel = 2'($urandom_range(0, 3));
                    r16 = 16'($urandom);
                    imm = {{16{r16[15]}}, r16};
                    jr  = $urandom;
                    if ($urandom_range(0, 1) == 1) jr[1:0] = 2'b00;
                end
                pcsel     = sel;
                signimm   = imm;
                jr_target = jr;
                m_pc  = ref_next(m_pc, sel, imm, m_instr, jr);
                m_ret = m_ret + 1;
                if (sel == 2'd3 && jr[1:0] != 2'b00) m_mis = 1'b1;
            end else begin
                pcsel     = 2'($urandom);
                signimm   = $urandom;
                jr_target = $urandom;
            end
        end
    end

    // Monitor: pops an expectation for every execute strobe; between strobes
    // the architectural state must match the model.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (enable) begin
                    if (exp_q.size() == 0) begin
                        chk("enable_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("exec_pc", pc, e.pc);
                        chk("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
                        chk("exec_instr", instr, e.ins);
                        chk("exec_retired", retired, e.ret);
                        chk("exec_misalign", 32'(misalign), 32'(e.mis));
                        chk("exec_req_low", 32'(imem_req), 32'd0);
                    end
                end else begin
                    chk("pc_track", pc, m_pc);
                    chk("retired_track", retired, m_ret);
                    chk("misalign_track", 32'(misalign), 32'(m_mis));
                end
            end
        end
    end

    initial begin : main
        int i;
        reset_n = 1'b0;
        run     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_retired", retired, 32'd0);

        // directed sequence: zero-wait, wait states, branch, J, JR, wrap
        dir_q.push_back('{0, 32'h0000_0001, 2'd0, 32'h0, 32'h0});
        dir_q.push_back('{0, 32'h0000_0002, 2'd0, 32'h0, 32'h0});
        dir_q.push_back('{0, 32'h0000_0003, 2'd0, 32'h0, 32'h0});
        dir_q.push_back('{3, 32'h0000_0004, 2'd0, 32'h0, 32'h0});
        dir_q.push_back('{1, 32'h1000_0005, 2'd1, 32'hFFFF_FFFE, 32'h0});
        dir_q.push_back('{2, 32'h0810_0020, 2'd2, 32'h0, 32'h0});
        dir_q.push_back('{0, 32'h0000_0007, 2'd3, 32'h0, 32'h0040_0102});
        dir_q.push_back('{0, 32'h0000_0008, 2'd3, 32'h0, 32'hFFFF_FFFC});
        dir_q.push_back('{0, 32'h0000_0009, 2'd0, 32'h0, 32'h0});
        dir_q.push_back('{3, 32'h0000_000A, 2'd0, 32'h0, 32'h0});

        @(posedge clk); #2;
        reset_n = 1'b1;
        run     = 1'b1;
        i = 0;
        while (m_ret < 10 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("directed_timeout", 32'(m_ret >= 10), 32'd1);

        // random phase with halts and resumes
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            run = ($urandom_range(0, 7) != 0);
        end

        // stall a fetch, then reset in the middle of it
        @(posedge clk); #2;
        run      = 1'b1;
        mem_en   = 1'b0;
        i = 0;
        while (!imem_req && i < 20) begin
            @(posedge clk); #2;
            i++;
        end
        chk("midfetch_req_seen", 32'(imem_req), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_retired", retired, 32'd0);
        chk("midrst_misalign", 32'(misalign), 32'd0);
        chk("midrst_instr", instr, 32'd0);
        run = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        mem_en  = 1'b1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("post_rst_instr", instr, 32'd0);
        chk("post_rst_pc", pc, RST_PC);
        chk("post_rst_retired", retired, 32'd0);
        chk("post_rst_idle_req", 32'(imem_req), 32'd0);

        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            run = ($urandom_range(0, 5) != 0);
        end

        run = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("drain_req", 32'(imem_req), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the MIPS datapath: owns the PC register, fetches from a variable-latency instruction memory over a req/ack handshake, and holds the instruction stable for one execute cycle.
- Drives the controller's `enable` with a one-cycle pulse per instruction, so register and memory writes happen exactly once.
- Consumes the controller's `pcsel` and the datapath's branch/jump/JR operands to form the next PC.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NBITS, 32, PC/data width (fixed 32 for MIPS; parameter kept for the bench).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = keep executing, 0 = halt after the current instruction retires.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  32  fetch address, equal to pc while imem_req is high.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr  out  32  latched instruction, stable from ack until the next fetch starts.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, modulo 2^32.
- enable  out  1  execute strobe to the controller; high exactly one cycle per instruction.
- pcsel  in  2  from the controller: 00 seq, 01 branch, 10 J/JAL, 11 JR.
- signimm  in  32  sign-extended immediate (instr[15:0]).
- jr_target  in  32  register-file read data 1.
- misalign  out  1  sticky; set when a JR target has bits[1:0]≠0.
- retired  out  32  count of executed instructions.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, pc=RESET_PC, instr=0, imem_req=0, enable=0, misalign=0, retired=0.
  - Takes effect immediately, including mid-fetch: imem_req drops the same cycle and any late ack is ignored.
- States:
  - IDLE → FETCH when run=1.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, latch instr←imem_rdata and go to EXEC. Zero-wait ack (same cycle as req rises) is legal: one FETCH cycle minimum.
  - EXEC: enable=1 for exactly this cycle; imem_req=0. At the clock edge: pc←next_pc, retired←retired+1, then → FETCH if run=1, else → HALT.
  - HALT: enable=0, imem_req=0, pc holds. → FETCH when run=1.
- Fetch is never aborted by run=0: the in-flight fetch completes and that instruction executes before halting.
- An instruction therefore takes at least 2 cycles (FETCH, EXEC).
- next_pc is combinational, evaluated in EXEC from the registered instr:
  - 00: pc_plus4.
  - 01: pc_plus4 + (signimm<<2), 32-bit wrap.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: {jr_target[31:2], 2'b00}; if jr_target[1:0]≠0, set misalign. misalign clears only on reset.
- Wrap: pc=32'hFFFF_FFFC with seq → 32'h0000_0000.
- retired wraps 32'hFFFF_FFFF → 0.
- imem_ack outside FETCH is ignored. imem_rdata is don't-care unless ack.
- pcsel is sampled only in EXEC; values in other states are ignored.
- Reset deasserts asynchronously; the design assumes external synchronisation of the release edge.

Decomposition:
- Shared package:
  - State enum {IDLE, FETCH, EXEC, HALT}.
  - pcsel encodings PCSEL_SEQ/BR/J/JR.
  - RESET_PC default constant.
- Sub-module `next_pc_mux`: combinational; inputs pcsel, pc_plus4, signimm, instr[25:0], jr_target; outputs next_pc and jr_misaligned.

Test Plan:
- Reset and zero-wait straight line: reset_n 0→1, run=1, ack same cycle as req, pcsel=00 → enable pulses every 2nd cycle; pc 0x00400000, 0x00400004, 0x00400008; retired=3 after 3 pulses.
- Wait states: ack delayed 3 cycles → imem_req high 4 cycles with imem_addr=pc constant, instr unchanged until ack, exactly one enable pulse.
- Branch/jump/JR:
  - pc=0x00400010, pcsel=01, signimm=32'hFFFF_FFFE → pc=0x0040000C.
  - pcsel=10, instr[25:0]=26'h0100020 → pc=0x00400080.
  - pcsel=11, jr_target=0x00400102 → pc=0x00400100, misalign=1 and stays 1.
- Halt/resume: run→0 during FETCH → fetch completes, one enable, then HALT with pc held; run→1 → next fetch at the updated pc.
- Reset mid-fetch: assert reset_n=0 while imem_req=1 → imem_req=0 immediately, pc=RESET_PC, retired=0; an ack the next cycle has no effect.
- Wrap: force pc=0xFFFFFFFC via a jump, pcsel=00 → pc=0x00000000, imem_addr=0 on the next fetch.
